// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect input and the
// valid/ready handshake toward decode. The master side is the fetch queue
// itself; the slave side is whatever surrounds it (ROM, execute, decode).
interface fetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rd;
    logic [31:0]           imem_q;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  dec_ready;
    logic                  dec_valid;
    logic [31:0]           dec_insn;
    logic [31:0]           dec_pc;
    logic [31:0]           dec_pc_plus1;
    logic [CNT_W-1:0]      occupancy;

    modport master (
        output imem_addr, imem_rd, dec_valid, dec_insn, dec_pc, dec_pc_plus1, occupancy,
        input  imem_q, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, imem_rd, dec_valid, dec_insn, dec_pc, dec_pc_plus1, occupancy,
        output imem_q, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the PC, issues one ROM read per cycle while
// there is room for the result, and buffers returned instructions (with
// their PCs) in a small FIFO that decode drains through valid/ready.
// A redirect flushes the FIFO, drops any in-flight read and reloads the PC.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.master fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] insn_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [SUM_W-1:0] pending;

    // Control decode: a read only issues if its result is guaranteed a slot,
    // counting the read already in flight; redirect blocks issue, push and pop.
    always_comb begin
        pending   = {1'b0, count} + SUM_W'(inflight);
        not_empty = (count != '0);
        issue     = !reset && !fq.redirect && (pending < DEPTH_S);
        push      = inflight && !fq.redirect;
        pop       = not_empty && fq.dec_ready && !fq.redirect;
    end

    // PC, in-flight tracking and FIFO bookkeeping; reset beats redirect beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (fq.redirect) begin
            pc       <= fq.redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + 32'd1;
                req_pc <= pc;
            end
            inflight <= issue;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: the returning ROM word is captured with the PC that requested it.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            insn_mem[tail] <= fq.imem_q;
            pc_mem[tail]   <= req_pc;
        end
    end

    assign fq.imem_rd      = issue;
    assign fq.imem_addr    = pc[ADDR_WIDTH-1:0];
    assign fq.dec_valid    = not_empty;
    assign fq.dec_insn     = not_empty ? insn_mem[head] : '0;
    assign fq.dec_pc       = not_empty ? pc_mem[head] : '0;
    assign fq.dec_pc_plus1 = not_empty ? pc_mem[head] + 32'd1 : '0;
    assign fq.occupancy    = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a directed vector table, hand-written redirect
// and wrap sequences, then randomized traffic against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 12;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic clock;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           insn;
        logic [31:0]           pc;
        logic [31:0]           pc1;
        logic [CNT_W-1:0]      occ;
        logic                  rd;
        logic [ADDR_WIDTH-1:0] addr;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        chk;
        logic        v;
        logic [31:0] pc;
        int          occ;
        logic        rd;
        logic [31:0] addr;
    } vec_t;

    // Instruction ROM contents as a function of word address.
    function automatic logic [31:0] rom(input logic [ADDR_WIDTH-1:0] a);
        return 32'h0000_1000 + 32'(a);
    endfunction

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous ROM with one cycle of read latency; garbage when not read.
    always @(posedge clock) begin
        bus.imem_q <= bus.imem_rd ? rom(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    function automatic obs_t expect_of(input logic v, input logic [31:0] pc, input int occ,
                                       input logic rd, input logic [31:0] addr);
        obs_t e;
        e.valid = v;
        e.insn  = v ? rom(pc[ADDR_WIDTH-1:0]) : 32'd0;
        e.pc    = v ? pc : 32'd0;
        e.pc1   = v ? pc + 32'd1 : 32'd0;
        e.occ   = CNT_W'(occ);
        e.rd    = rd;
        e.addr  = addr[ADDR_WIDTH-1:0];
        return e;
    endfunction

    function automatic vec_t mk(input int rst, input int rdy, input int chk, input int v,
                                input int pc, input int occ, input int rd, input int addr);
        vec_t t;
        t.rst  = (rst != 0);
        t.rdy  = (rdy != 0);
        t.chk  = (chk != 0);
        t.v    = (v != 0);
        t.pc   = 32'(pc);
        t.occ  = occ;
        t.rd   = (rd != 0);
        t.addr = 32'(addr);
        return t;
    endfunction

    task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                                 input logic rdy);
        @(negedge clock);
        reset           = rst;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.dec_ready   = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act.valid = bus.dec_valid;
        act.insn  = bus.dec_insn;
        act.pc    = bus.dec_pc;
        act.pc1   = bus.dec_pc_plus1;
        act.occ   = bus.occupancy;
        act.rd    = bus.imem_rd;
        act.addr  = bus.imem_addr;
        compared++;
        if (act !== exp || int'(bus.occupancy) > DEPTH) begin
            mismatched++;
            $display("[TB] FAIL %s: got v=%0b insn=%h pc=%h pc1=%h occ=%0d rd=%0b addr=%h, want v=%0b insn=%h pc=%h pc1=%h occ=%0d rd=%0b addr=%h",
                     name, act.valid, act.insn, act.pc, act.pc1, act.occ, act.rd, act.addr,
                     exp.valid, exp.insn, exp.pc, exp.pc1, exp.occ, exp.rd, exp.addr);
        end
    endtask

    task automatic step(input string name, input int rst, input int redir, input logic [31:0] rpc,
                        input int rdy, input int v, input logic [31:0] pc, input int occ,
                        input int rd, input logic [31:0] addr);
        applyStimulus(rst != 0, redir != 0, rpc, rdy != 0);
        checkOutput(name, expect_of(v != 0, pc, occ, rd != 0, addr));
    endtask

    // Reference model: queue of buffered PCs, at most one pending read, and the fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mpend[$];
    logic [31:0] mpc;

    function automatic logic model_issue(input logic rst, input logic redir);
        return !rst && !redir && ((mq.size() + mpend.size()) < DEPTH);
    endfunction

    task automatic model_step(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic rdy);
        logic iss;
        iss = model_issue(rst, redir);
        if (rst) begin
            mq.delete();
            mpend.delete();
            mpc = 32'd0;
        end else if (redir) begin
            mq.delete();
            mpend.delete();
            mpc = rpc;
        end else begin
            if (mq.size() > 0 && rdy) begin
                void'(mq.pop_front());
            end
            if (mpend.size() > 0) begin
                mq.push_back(mpend.pop_front());
            end
            if (iss) begin
                mpend.push_back(mpc);
                mpc = mpc + 32'd1;
            end
        end
    endtask

    vec_t tbl[20];

    initial begin
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.dec_ready   = 1'b0;

        // Fill-to-full with decode stalled, drain, reset mid-flight, full-rate refetch.
        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, 1, 1);
        tbl[3]  = mk(0, 0, 1, 1, 0, 1, 1, 2);
        tbl[4]  = mk(0, 0, 1, 1, 0, 2, 1, 3);
        tbl[5]  = mk(0, 0, 1, 1, 0, 3, 0, 4);
        tbl[6]  = mk(0, 0, 1, 1, 0, 4, 0, 4);
        tbl[7]  = mk(0, 0, 1, 1, 0, 4, 0, 4);
        tbl[8]  = mk(0, 1, 1, 1, 0, 4, 0, 4);
        tbl[9]  = mk(0, 1, 1, 1, 1, 3, 1, 4);
        tbl[10] = mk(0, 1, 1, 1, 2, 2, 1, 5);
        tbl[11] = mk(0, 1, 1, 1, 3, 2, 1, 6);
        tbl[12] = mk(0, 1, 1, 1, 4, 2, 1, 7);
        tbl[13] = mk(0, 1, 1, 1, 5, 2, 1, 8);
        tbl[14] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 1, 0);
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 1, 1);
        tbl[17] = mk(0, 1, 1, 1, 0, 1, 1, 2);
        tbl[18] = mk(0, 1, 1, 1, 1, 1, 1, 3);
        tbl[19] = mk(0, 1, 1, 1, 2, 1, 1, 4);

        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].rst, 1'b0, 32'd0, tbl[i].rdy);
            if (tbl[i].chk) begin
                checkOutput($sformatf("vec%0d", i),
                            expect_of(tbl[i].v, tbl[i].pc, tbl[i].occ, tbl[i].rd, tbl[i].addr));
            end
        end

        // Redirect with three entries buffered and a read in flight.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        step("redirA_c0", 0, 0, 32'd0,  0, 0, 32'd0,    0, 1, 32'd0);
        step("redirA_c1", 0, 0, 32'd0,  0, 0, 32'd0,    0, 1, 32'd1);
        step("redirA_c2", 0, 0, 32'd0,  0, 1, 32'd0,    1, 1, 32'd2);
        step("redirA_c3", 0, 0, 32'd0,  0, 1, 32'd0,    2, 1, 32'd3);
        step("redirA_r",  0, 1, 32'h20, 0, 1, 32'd0,    3, 0, 32'd4);
        step("redirA_r1", 0, 0, 32'd0,  0, 0, 32'd0,    0, 1, 32'h20);
        step("redirA_r2", 0, 0, 32'd0,  0, 0, 32'd0,    0, 1, 32'h21);

        // Redirect coinciding with a handshake: no pop, head not consumed twice.
        step("redirB_r",  0, 1, 32'h40, 1, 1, 32'h20,   1, 0, 32'h22);
        step("redirB_r1", 0, 0, 32'd0,  1, 0, 32'd0,    0, 1, 32'h40);
        step("redirB_r2", 0, 0, 32'd0,  1, 0, 32'd0,    0, 1, 32'h41);
        step("redirB_r3", 0, 0, 32'd0,  1, 1, 32'h40,   1, 1, 32'h42);
        step("redirB_r4", 0, 0, 32'd0,  1, 1, 32'h41,   1, 1, 32'h43);

        // Redirect to the top of the address space: PC and ROM address wrap.
        step("wrap_r",    0, 1, 32'hFFFF_FFFF, 1, 1, 32'h42, 1, 0, 32'h44);
        step("wrap_r1",   0, 0, 32'd0, 1, 0, 32'd0,          0, 1, 32'hFFF);
        step("wrap_r2",   0, 0, 32'd0, 1, 0, 32'd0,          0, 1, 32'h000);
        step("wrap_r3",   0, 0, 32'd0, 1, 1, 32'hFFFF_FFFF,  1, 1, 32'h001);
        step("wrap_r4",   0, 0, 32'd0, 1, 1, 32'h0000_0000,  1, 1, 32'h002);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic        rst;
            logic        redir;
            logic [31:0] rpc;
            logic        rdy;
            rst   = (i < 2) || ($urandom_range(99) == 0);
            redir = !rst && ($urandom_range(19) == 0);
            rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3)) : $urandom;
            rdy   = ($urandom_range(9) < 7);
            applyStimulus(rst, redir, rpc, rdy);
            if (i >= 1) begin
                checkOutput($sformatf("rand%0d", i),
                            expect_of(mq.size() > 0, (mq.size() > 0) ? mq[0] : 32'd0,
                                      mq.size(), model_issue(rst, redir), mpc));
            end
            model_step(rst, redir, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the decode stage that classifies opcodes into R/I/JI/JII types.
- Owns the PC, issues word addresses to the synchronous instruction ROM (1-cycle read latency) and buffers returned instructions in a small FIFO.
- Presents buffered instructions to decode through a valid/ready handshake.
- Accepts a redirect (taken branch/jump/jr from execute), which flushes the buffer, kills in-flight reads and reloads the PC.

Parameters:
- DEPTH, 4, buffer entries; power of 2, minimum 2.
- ADDR_WIDTH, 12, instruction ROM word-address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_WIDTH  ROM address, equal to pc[ADDR_WIDTH-1:0]
- imem_rd  out  1  fetch issued this cycle
- imem_q  in  32  ROM data, valid the cycle after imem_rd
- redirect  in  1  flush and load redirect_pc
- redirect_pc  in  32  new fetch PC (word address)
- dec_ready  in  1  decode accepts head entry
- dec_valid  out  1  head entry valid
- dec_insn  out  32  head instruction
- dec_pc  out  32  PC of head instruction
- dec_pc_plus1  out  32  dec_pc + 1, mod 2^32
- occupancy  out  clog2(DEPTH)+1  entries held

Behaviour:
- Clock and reset: one clock (clock); reset synchronous, active-high. All state changes on the rising edge of clock.
- Reset values:
  - pc = 0; buffer empty; occupancy = 0; in-flight flag = 0.
  - dec_valid = 0, imem_rd = 0, imem_addr = 0.
  - dec_insn, dec_pc and dec_pc_plus1 read as 0 while the buffer is empty.
- Reset mid-operation: a read outstanding at reset is discarded, and its data does not enter the buffer.
- Issue:
  - imem_rd = !reset && !redirect && (occupancy + inflight < DEPTH), evaluated on registered state.
  - On issue, pc <= pc + 1 (32-bit wrap), and the issuing PC is latched as req_pc with inflight <= 1.
  - At most one read per cycle.
- Return:
  - In the cycle after an issue, if that issue was not killed, {req_pc, imem_q} is written at the tail.
  - Throughput is 1 instruction/cycle when decode drains every cycle.
  - inflight clears unless a new issue happens the same cycle.
- Pop: when dec_valid && dec_ready && !redirect, the head advances.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Push into a buffer that then holds DEPTH entries is legal.
  - The issue rule guarantees no overflow; pushing while full is a design error (assert in the bench).
- Empty: dec_valid = 0. A pushed entry is visible at dec_valid the cycle after the push, with no bypass of imem_q to decode.
- Redirect (takes priority over all else):
  - pc <= redirect_pc and the buffer is cleared (occupancy 0, pointers reset).
  - Any response returning this cycle or from an issue in this cycle is dropped.
  - No issue in the redirect cycle; the first fetch of redirect_pc issues the next cycle, and its instruction is valid to decode 3 cycles after redirect is asserted.
  - A pop is suppressed in the redirect cycle even if dec_ready = 1.
- Wrap:
  - FIFO pointers wrap mod DEPTH.
  - PC wraps 0xFFFFFFFF -> 0.
  - imem_addr uses the low ADDR_WIDTH bits only.
- Outputs dec_insn, dec_pc and dec_pc_plus1 are stable while dec_valid && !dec_ready.

Test Plan:
- Reset, then release with dec_ready = 1, ROM[i] = 0x1000+i -> imem_rd high from cycle 0; dec_valid first at cycle 2 with insn 0x1000, pc 0, pc_plus1 1; then one instruction per cycle in order.
- dec_ready = 0 throughout -> exactly DEPTH (4) entries fetched, occupancy = 4, imem_rd low thereafter. Raise dec_ready -> entries 0..3 drain in order and fetch resumes at pc 4 with no loss or duplication.
- Redirect to 0x20 while occupancy = 3 and a read is in flight -> next cycle occupancy = 0 and dec_valid = 0. The stale in-flight data never appears; the first valid entry has pc 0x20, 3 cycles after redirect.
- Redirect in the same cycle as dec_valid && dec_ready -> no pop is counted, and the head is not consumed twice afterward.
- Redirect to 0xFFFFFFFF -> entries carry pc 0xFFFFFFFF then 0x00000000; imem_addr = 0xFFF then 0x000; pc_plus1 of the first entry is 0.
- Assert reset for one cycle while occupancy = 2 and a read is in flight -> all outputs return to reset values the next cycle, and refetch starts at pc 0.
